neuromorphic_xn_core: RTL and testbench

//  Synthesizable, parametrised successor of the 32x32 behavioural ReRAM core. Sits behind the

---
 rtl/neuromorphic_xn_core_pkg.sv | 56 +++++
 rtl/neuromorphic_xn_core_fifo.sv | 52 +++++
 rtl/neuromorphic_xn_core.sv | 179 +++++++++++++++++
 tb/tb_neuromorphic_xn_core.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuromorphic_xn_core_pkg.sv
// Shared encodings for the ReRAM core: command fields, result tags, engine states.
// Pure declarations; no latency or flow control of its own.
package nmx_pkg;

  typedef enum logic [1:0] {
    MODE_NOP  = 2'b00,
    MODE_READ = 2'b01,
    MODE_FORM = 2'b10,
    MODE_PROG = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT
  } eng_state_e;

  localparam int MODE_MSB = 31;
  localparam int MODE_LSB = 30;
  localparam int ROW_MSB  = 29;
  localparam int ROW_LSB  = 25;
  localparam int COL_MSB  = 24;
  localparam int COL_LSB  = 20;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [31:0] EMPTY_WORD = 32'hDEAD_C0DE;
  localparam logic [1:0]  RES_OK     = 2'b01;
  localparam logic [1:0]  RES_ERR    = 2'b10;

  typedef struct packed {
    logic [1:0]  tag;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [18:0] rsvd;
    logic        bit_val;
  } res_t;

  function automatic res_t mk_res(input logic [1:0] tag, input logic [4:0] row,
                                  input logic [4:0] col, input logic b);
    res_t r;
    r.tag     = tag;
    r.row     = row;
    r.col     = col;
    r.rsvd    = '0;
    r.bit_val = b;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/neuromorphic_xn_core_fifo.sv
// Count-based synchronous FIFO, first-word fall-through, zero-cycle read of the head.
// Push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module nmx_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 32
) (
  input  logic         CLKin,
  input  logic         RSTin,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = out_rdy && !empty;
  assign do_push = in_vld && (!full || do_pop);
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLKin) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end

endmodule

// File: rtl/neuromorphic_xn_core.sv
// ReRAM crossbar core behind a single-address WB shim; pop-to-effect latency is RD/WR/FORM_DLY.
// Writes stall un-acked while the command FIFO is full; READs hold in the engine while results are full.
module neuromorphic_xn_core
  import nmx_pkg::*;
#(
  parameter int          ROWS     = 32,
  parameter int          COLS     = 32,
  parameter int          IP_DEPTH = 32,
  parameter int          OP_DEPTH = 32,
  parameter int          RD_DLY   = 44,
  parameter int          WR_DLY   = 200,
  parameter int          FORM_DLY = 1000,
  parameter logic [7:0]  THRESH   = 8'h7F,
  parameter bit          REQ_FORM = 1'b0
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        EN,
  input  logic        W_RB,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        core_ack,
  output logic        busy,
  output logic        ip_full,
  output logic        op_empty,
  output logic        err
);

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(max3(RD_DLY, WR_DLY, FORM_DLY) + 1);

  logic        ip_push, ip_pop, ip_empty;
  logic        op_push, op_pop, op_full;
  logic [31:0] ip_head, op_head;
  res_t        op_dat;

  eng_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cmd_q, cmd_d;
  logic             arr_we, form_we, err_set;

  // Non-volatile cells: deliberately outside the reset domain.
  logic [COLS-1:0] arr [ROWS];
  logic [ROWS-1:0] formed;

  nmx_sync_fifo #(.W(32), .DEPTH(IP_DEPTH)) u_ip_fifo (
    .CLKin(CLKin), .RSTin(RSTin),
    .in_vld(ip_push), .in_dat(DI),
    .out_rdy(ip_pop), .out_dat(ip_head),
    .full(ip_full), .empty(ip_empty)
  );

  nmx_sync_fifo #(.W(32), .DEPTH(OP_DEPTH)) u_op_fifo (
    .CLKin(CLKin), .RSTin(RSTin),
    .in_vld(op_push), .in_dat(op_dat),
    .out_rdy(op_pop), .out_dat(op_head),
    .full(op_full), .empty(op_empty)
  );

  // Blocking on core_ack keeps the held strobe of the acked cycle from being serviced twice.
  logic bus_req;
  assign bus_req = EN && !core_ack;
  assign ip_push = bus_req && W_RB && !ip_full;
  assign op_pop  = bus_req && !W_RB && !op_empty;

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      DO       <= '0;
      core_ack <= 1'b0;
    end else begin
      core_ack <= ip_push || (bus_req && !W_RB);
      if (bus_req && !W_RB) DO <= op_empty ? EMPTY_WORD : op_head;
    end
  end

  mode_e        c_mode, h_mode;
  logic [4:0]   c_row, c_col;
  logic [7:0]   c_dat;
  logic [RW-1:0] ridx;
  logic [CW-1:0] cidx;
  logic         cmd_bad;
  logic         unused_cmd_bits;

  assign h_mode = mode_e'(ip_head[MODE_MSB:MODE_LSB]);
  assign c_mode = mode_e'(cmd_q[MODE_MSB:MODE_LSB]);
  assign c_row  = cmd_q[ROW_MSB:ROW_LSB];
  assign c_col  = cmd_q[COL_MSB:COL_LSB];
  assign c_dat  = cmd_q[DATA_MSB:DATA_LSB];
  assign ridx   = c_row[RW-1:0];
  assign cidx   = c_col[CW-1:0];
  assign unused_cmd_bits = ^cmd_q[COL_LSB-1:DATA_MSB+1];

  assign cmd_bad = (int'(c_row) >= ROWS) || (int'(c_col) >= COLS) ||
                   (REQ_FORM && (c_mode != MODE_FORM) && !formed[ridx]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    ip_pop  = 1'b0;
    op_push = 1'b0;
    op_dat  = mk_res(RES_OK, c_row, c_col, arr[ridx][cidx]);
    arr_we  = 1'b0;
    form_we = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ip_empty) begin
          case (h_mode)
            MODE_NOP:  ip_pop = 1'b1;
            MODE_READ: begin
              if (!op_full) begin
                ip_pop  = 1'b1;
                cnt_d   = CNT_W'(RD_DLY - 1);
                state_d = ST_WAIT;
              end
            end
            MODE_PROG: begin
              ip_pop  = 1'b1;
              cnt_d   = CNT_W'(WR_DLY - 1);
              state_d = ST_WAIT;
            end
            default: begin
              ip_pop  = 1'b1;
              cnt_d   = CNT_W'(FORM_DLY - 1);
              state_d = ST_WAIT;
            end
          endcase
          if (ip_pop) cmd_d = ip_head;
        end
      end
      // Leaving on cnt==1 places the commit edge exactly DLY cycles after the pop edge.
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_COMMIT;
      end
      default: begin
        state_d = ST_IDLE;
        if (cmd_bad) begin
          err_set = 1'b1;
          if (c_mode == MODE_READ) begin
            op_push = 1'b1;
            op_dat  = mk_res(RES_ERR, c_row, c_col, 1'b0);
          end
        end else begin
          case (c_mode)
            MODE_PROG: arr_we  = 1'b1;
            MODE_READ: op_push = 1'b1;
            MODE_FORM: form_we = 1'b1;
            default:   ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      err     <= err | err_set;
    end
  end

  always_ff @(posedge CLKin) begin
    if (arr_we)  arr[ridx][cidx] <= (c_dat > THRESH);
    if (form_we) formed[ridx]    <= 1'b1;
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neuromorphic_xn_core.sv
// Randomised + directed scoreboard bench for neuromorphic_xn_core against an array-level model.
module tb_neuromorphic_xn_core;

  localparam int         ROWS = 16;
  localparam int         COLS = 24;
  localparam int         IPD  = 8;
  localparam int         OPD  = 4;
  localparam int         RD   = 44;
  localparam int         WR   = 200;
  localparam int         FM   = 1000;
  localparam logic [7:0] TH   = 8'h7F;
  localparam logic [31:0] EMPTY = 32'hDEAD_C0DE;

  logic        CLKin = 1'b0;
  logic        RSTin = 1'b1;
  logic        EN = 1'b0;
  logic        W_RB = 1'b0;
  logic [31:0] DI = '0;
  logic [31:0] DO;
  logic        core_ack, busy, ip_full, op_empty, err;

  neuromorphic_xn_core #(
    .ROWS(ROWS), .COLS(COLS), .IP_DEPTH(IPD), .OP_DEPTH(OPD),
    .RD_DLY(RD), .WR_DLY(WR), .FORM_DLY(FM), .THRESH(TH), .REQ_FORM(1'b1)
  ) dut (
    .CLKin(CLKin), .RSTin(RSTin), .EN(EN), .W_RB(W_RB), .DI(DI), .DO(DO),
    .core_ack(core_ack), .busy(busy), .ip_full(ip_full), .op_empty(op_empty), .err(err)
  );

  always #5 CLKin = ~CLKin;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pend = 0;
  bit m_arr [32][32];
  bit m_formed [32];
  bit m_err = 1'b0;
  logic [31:0] exp_q[$];
  bit kind_q[$];
  int busy_rise = 0, busy_fall = 0, ope_fall = 0;
  bit prev_busy = 1'b0, prev_ope = 1'b1, prev_ack = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired t=%0t", nm, $time);
  endfunction

  // Array-level reference: applies each accepted command in issue order.
  function automatic void model_cmd(input logic [31:0] c);
    logic [1:0] md;
    int r, cl;
    bit bad_c;
    md = c[31:30];
    r  = int'(c[29:25]);
    cl = int'(c[24:20]);
    if (md == 2'b00) return;
    if (md == 2'b01) pend++;
    bad_c = (r >= ROWS) || (cl >= COLS) || (md != 2'b10 && !m_formed[r]);
    if (bad_c) begin
      m_err = 1'b1;
      if (md == 2'b01) exp_q.push_back({2'b10, c[29:25], c[24:20], 19'b0, 1'b0});
      return;
    end
    case (md)
      2'b11:   m_arr[r][cl] = (c[7:0] > TH);
      2'b01:   exp_q.push_back({2'b01, c[29:25], c[24:20], 19'b0, m_arr[r][cl]});
      default: m_formed[r] = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] md, input int r, input int c, input int d);
    logic [4:0] rr, cc;
    logic [7:0] dd;
    logic [11:0] junk;
    rr = 5'(r);
    cc = 5'(c);
    dd = 8'(d);
    junk = 12'($urandom);
    return {md, rr, cc, junk, dd};
  endfunction

  always @(posedge CLKin) cyc <= cyc + 1;

  // Monitor: edge timestamps plus scoreboard comparison of every read acknowledge.
  always @(negedge CLKin) begin
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    if (!op_empty && prev_ope) ope_fall = cyc;
    if (core_ack) begin
      check("ack_single_cycle", 32'(prev_ack), 32'd0);
      if (!W_RB) begin
        if (kind_q.size() == 0) fail("read_ack_unexpected");
        else if (kind_q.pop_front()) check("empty_read_do", DO, EMPTY);
        else if (exp_q.size() == 0) fail("result_unexpected");
        else check("result_do", DO, exp_q.pop_front());
      end
    end
    prev_busy = busy;
    prev_ope  = op_empty;
    prev_ack  = core_ack;
  end

  task automatic wb_write(input logic [31:0] c, input bit apply);
    int n;
    n = 0;
    @(negedge CLKin);
    EN = 1'b1; W_RB = 1'b1; DI = c;
    @(posedge CLKin); #1;
    while (!core_ack && n < 10000) begin @(posedge CLKin); #1; n++; end
    EN = 1'b0;
    if (!core_ack) fail("write_ack");
    else if (apply) model_cmd(c);
    @(posedge CLKin);
  endtask

  task automatic wb_read(input bit expect_empty);
    int n;
    n = 0;
    if (!expect_empty) begin
      while (op_empty && n < 15000) begin @(posedge CLKin); #1; n++; end
      if (op_empty) begin fail("result_wait"); pend--; return; end
    end
    @(negedge CLKin);
    kind_q.push_back(expect_empty);
    EN = 1'b1; W_RB = 1'b0;
    n = 0;
    @(posedge CLKin); #1;
    while (!core_ack && n < 100) begin @(posedge CLKin); #1; n++; end
    EN = 1'b0;
    if (!core_ack) fail("read_ack");
    if (!expect_empty) pend--;
    @(posedge CLKin);
  endtask

  task automatic wait_idle();
    int n, quiet;
    n = 0; quiet = 0;
    while (quiet < 2 && n < 20000) begin
      @(posedge CLKin); #1; n++;
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 2) fail("idle_wait");
  endtask

  task automatic drain();
    while (pend > 0) wb_read(1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, n, r;
    logic [31:0] c;

    repeat (3) @(posedge CLKin);
    #1;
    check("rst_do", DO, 32'd0);
    check("rst_ack", 32'(core_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ip_full", 32'(ip_full), 32'd0);
    check("rst_op_empty", 32'(op_empty), 32'd1);
    @(negedge CLKin) RSTin = 1'b0;

    wb_read(1'b1);
    #1 check("op_empty_after_empty_read", 32'(op_empty), 32'd1);

    // Unformed row rejected, then forming enables it; latencies measured on isolated commands.
    wb_write(mk(2'b11, 2, 1, 8'hFF), 1'b1);
    wb_write(mk(2'b01, 2, 1, 0), 1'b1);
    drain();
    wait_idle();
    check("err_unformed", 32'(err), 32'd1);
    wb_write(mk(2'b10, 2, 0, 0), 1'b1);
    wait_idle();
    check("form_latency", 32'(busy_fall - busy_rise), 32'(FM));
    wb_write(mk(2'b11, 2, 1, 8'hFF), 1'b1);
    wait_idle();
    check("prog_latency", 32'(busy_fall - busy_rise), 32'(WR));
    wb_write(mk(2'b01, 2, 1, 0), 1'b1);
    wait_idle();
    check("read_busy_latency", 32'(busy_fall - busy_rise), 32'(RD));
    check("read_result_latency", 32'(ope_fall - busy_rise), 32'(RD));
    drain();

    // Threshold boundary on r3 c7, then an out-of-range row.
    wb_write(mk(2'b10, 3, 0, 0), 1'b1);
    wb_write(mk(2'b11, 3, 7, 8'h80), 1'b1);
    wb_write(mk(2'b01, 3, 7, 0), 1'b1);
    wb_write(mk(2'b11, 3, 7, 8'h7F), 1'b1);
    wb_write(mk(2'b01, 3, 7, 0), 1'b1);
    wb_write(mk(2'b01, 31, 31, 0), 1'b1);
    drain();
    wait_idle();
    check("err_row_range", 32'(err), 32'd1);

    // Fill the command FIFO behind a long FORM; the next write must stall until a pop.
    wb_write(mk(2'b10, 5, 0, 0), 1'b1);
    for (int i = 0; i < IPD; i++) wb_write(mk(2'b01, 3, $urandom_range(0, COLS-1), 0), 1'b1);
    #1 check("ip_full_after_fill", 32'(ip_full), 32'd1);
    c = mk(2'b01, 5, 0, 0);
    @(negedge CLKin);
    EN = 1'b1; W_RB = 1'b1; DI = c;
    acks = 0;
    repeat (30) begin @(posedge CLKin); #1; if (core_ack) acks++; end
    check("stall_no_ack", 32'(acks), 32'd0);
    n = 0;
    while (!core_ack && n < 2000) begin @(posedge CLKin); #1; n++; end
    EN = 1'b0;
    if (!core_ack) fail("stall_release");
    else model_cmd(c);
    @(posedge CLKin);
    drain();
    wait_idle();

    // Reset during WAIT of a PROGRAM: the cell keeps its previous value.
    wb_write(mk(2'b11, 3, 7, 8'hFF), 1'b1);
    wait_idle();
    wb_write(mk(2'b11, 3, 7, 8'h00), 1'b0);
    repeat (50) @(posedge CLKin);
    #1 check("busy_in_wait", 32'(busy), 32'd1);
    @(negedge CLKin) RSTin = 1'b1;
    #1;
    m_err = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_op_empty", 32'(op_empty), 32'd1);
    check("midrst_ip_full", 32'(ip_full), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    repeat (2) @(posedge CLKin);
    @(negedge CLKin) RSTin = 1'b0;
    wb_write(mk(2'b01, 3, 7, 0), 1'b1);
    drain();

    // Random traffic; outstanding results are kept within the result FIFO depth.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      c = mk(2'b10, $urandom_range(0, 17), $urandom_range(0, 25), 0);
      else if (r < 4)  c = mk(2'b00, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 255));
      else if (r < 10) c = mk(2'b11, $urandom_range(0, 17), $urandom_range(0, 25), $urandom_range(0, 255));
      else             c = mk(2'b01, $urandom_range(0, 17), $urandom_range(0, 25), 0);
      if (c[31:30] == 2'b01 && pend >= OPD) wb_read(1'b0);
      wb_write(c, 1'b1);
      if (pend > 0 && $urandom_range(0, 2) == 0) wb_read(1'b0);
    end
    drain();
    wait_idle();
    check("final_err", 32'(err), 32'(m_err));
    check("final_op_empty", 32'(op_empty), 32'd1);
    check("final_ip_full", 32'(ip_full), 32'd0);
    check("final_exp_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
